// File: rtl/ctrl_bubble_stage.sv
// rtl/ctrl_bubble_stage.sv - ID/EX control register with programmable bubble insertion, stall freeze and flush
module ctrl_bubble_stage #(
    parameter int                 CTRL_W    = 12,
    parameter logic [CTRL_W-1:0]  NOP_VALUE = {CTRL_W{1'b0}},
    parameter int                 CNT_W     = 3,
    parameter int                 TOT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              valid_in,
    input  logic              stall,
    input  logic              flush,
    input  logic              bubble_req,
    input  logic [CNT_W-1:0]  bubble_cnt,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              valid_out,
    output logic              hold_upstream,
    output logic              busy,
    output logic [TOT_W-1:0]  bubble_total
);

    typedef enum logic {PASS = 1'b0, BUBBLE = 1'b1} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  rem_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              valid_q;
    logic [TOT_W-1:0]  total_q;
    logic [TOT_W-1:0]  total_d;
    logic              req_active;

    assign req_active = bubble_req && (bubble_cnt != '0);

    // Saturating increment; only applied on edges that actually emit a bubble.
    assign total_d = (&total_q) ? total_q : total_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PASS;
            rem_q   <= '0;
            ctrl_q  <= NOP_VALUE;
            valid_q <= 1'b0;
            total_q <= '0;
        end else if (flush) begin
            state_q <= PASS;
            rem_q   <= '0;
            ctrl_q  <= NOP_VALUE;
            valid_q <= 1'b0;
        end else if (!stall) begin
            if (state_q == BUBBLE) begin
                ctrl_q  <= NOP_VALUE;
                valid_q <= 1'b0;
                rem_q   <= rem_q - 1'b1;
                total_q <= total_d;
                if (rem_q == CNT_W'(1)) begin
                    state_q <= PASS;
                end
            end else if (req_active) begin
                ctrl_q  <= NOP_VALUE;
                valid_q <= 1'b0;
                rem_q   <= bubble_cnt - 1'b1;
                total_q <= total_d;
                state_q <= (bubble_cnt > CNT_W'(1)) ? BUBBLE : PASS;
            end else if (valid_in) begin
                ctrl_q  <= ctrl_in;
                valid_q <= 1'b1;
            end else begin
                ctrl_q  <= NOP_VALUE;
                valid_q <= 1'b0;
            end
        end
    end

    assign hold_upstream = !reset &&
                           (stall || (state_q == BUBBLE) || ((state_q == PASS) && req_active));
    assign ctrl_out      = ctrl_q;
    assign valid_out     = valid_q;
    assign busy          = (state_q == BUBBLE);
    assign bubble_total  = total_q;

endmodule

// File: tb/tb_ctrl_bubble_stage.sv
// tb/tb_ctrl_bubble_stage.sv - table-driven scoreboard bench for ctrl_bubble_stage
module tb_ctrl_bubble_stage;

    logic        clk = 1'b0;
    logic        reset, flush, stall, bubble_req, valid_in;
    logic [2:0]  bubble_cnt;
    logic [11:0] ctrl_in;
    logic [11:0] ctrl_out, ctrl_out2;
    logic        valid_out, hold_upstream, busy;
    logic        valid_out2, hold_upstream2, busy2;
    logic [15:0] bubble_total;
    logic [1:0]  bubble_total2;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    ctrl_bubble_stage dut (
        .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .valid_in(valid_in),
        .stall(stall), .flush(flush), .bubble_req(bubble_req), .bubble_cnt(bubble_cnt),
        .ctrl_out(ctrl_out), .valid_out(valid_out), .hold_upstream(hold_upstream),
        .busy(busy), .bubble_total(bubble_total)
    );

    ctrl_bubble_stage #(.TOT_W(2)) dut2 (
        .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .valid_in(valid_in),
        .stall(stall), .flush(flush), .bubble_req(bubble_req), .bubble_cnt(bubble_cnt),
        .ctrl_out(ctrl_out2), .valid_out(valid_out2), .hold_upstream(hold_upstream2),
        .busy(busy2), .bubble_total(bubble_total2)
    );

    typedef struct {
        logic        rst, fl, st, br;
        logic [2:0]  bc;
        logic        vi;
        logic [11:0] ci;
        logic        hold;
        logic [11:0] ec;
        logic        ev, eb;
        logic [15:0] et;
    } vec_t;

    typedef struct packed {
        logic [11:0] ec;
        logic        ev, eb;
        logic [15:0] et;
    } exp_t;

    vec_t tbl[30];
    exp_t sb_q[$];

    function automatic vec_t mk(logic rst, logic fl, logic st, logic br, logic [2:0] bc,
                                logic vi, logic [11:0] ci, logic hold, logic [11:0] ec,
                                logic ev, logic eb, logic [15:0] et);
        vec_t v;
        v.rst = rst; v.fl = fl; v.st = st; v.br = br; v.bc = bc; v.vi = vi; v.ci = ci;
        v.hold = hold; v.ec = ec; v.ev = ev; v.eb = eb; v.et = et;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic drive(input logic rst, input logic fl, input logic st, input logic br,
                         input logic [2:0] bc, input logic vi, input logic [11:0] ci);
        reset = rst; flush = fl; stall = st; bubble_req = br; bubble_cnt = bc;
        valid_in = vi; ctrl_in = ci;
    endtask

    initial begin
        exp_t e;
        drive(1, 0, 0, 0, 0, 1, 12'hFFF);
        //          rst fl st br bc vi ci       hold ctrl    v  b  total
        tbl[0]  = mk(1, 0, 0, 0, 0, 1, 12'hFFF, 0, 12'h000, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 1, 12'hFFF, 0, 12'h000, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 1, 12'hFFF, 0, 12'hFFF, 1, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 1, 12'h123, 0, 12'h123, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 1, 12'h456, 0, 12'h456, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 12'h789, 0, 12'h000, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 1, 12'h789, 0, 12'h789, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0, 1, 3, 1, 12'h0A5, 1, 12'h000, 0, 1, 1);
        tbl[8]  = mk(0, 0, 0, 0, 0, 1, 12'h0A5, 1, 12'h000, 0, 1, 2);
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, 12'h0A5, 1, 12'h000, 0, 0, 3);
        tbl[10] = mk(0, 0, 0, 0, 0, 1, 12'h0A5, 0, 12'h0A5, 1, 0, 3);
        tbl[11] = mk(0, 0, 0, 1, 2, 1, 12'h0B6, 1, 12'h000, 0, 1, 4);
        tbl[12] = mk(0, 0, 1, 0, 0, 1, 12'h0B6, 1, 12'h000, 0, 1, 4);
        tbl[13] = mk(0, 0, 1, 0, 0, 1, 12'h0B6, 1, 12'h000, 0, 1, 4);
        tbl[14] = mk(0, 0, 0, 0, 0, 1, 12'h0B6, 1, 12'h000, 0, 0, 5);
        tbl[15] = mk(0, 0, 0, 0, 0, 1, 12'h0B6, 0, 12'h0B6, 1, 0, 5);
        tbl[16] = mk(0, 0, 0, 1, 3, 1, 12'h0C7, 1, 12'h000, 0, 1, 6);
        tbl[17] = mk(0, 1, 0, 0, 0, 1, 12'h0C7, 1, 12'h000, 0, 0, 6);
        tbl[18] = mk(0, 0, 0, 0, 0, 1, 12'h0D8, 0, 12'h0D8, 1, 0, 6);
        tbl[19] = mk(0, 0, 0, 1, 2, 1, 12'h0E9, 1, 12'h000, 0, 1, 7);
        tbl[20] = mk(0, 1, 1, 0, 0, 1, 12'h0E9, 1, 12'h000, 0, 0, 7);
        tbl[21] = mk(0, 0, 0, 0, 0, 1, 12'h0FA, 0, 12'h0FA, 1, 0, 7);
        tbl[22] = mk(0, 1, 0, 0, 0, 1, 12'h111, 0, 12'h000, 0, 0, 7);
        tbl[23] = mk(0, 0, 0, 1, 0, 1, 12'h222, 0, 12'h222, 1, 0, 7);
        tbl[24] = mk(0, 0, 1, 0, 0, 1, 12'h333, 1, 12'h222, 1, 0, 7);
        tbl[25] = mk(0, 0, 0, 1, 1, 1, 12'h444, 1, 12'h000, 0, 0, 8);
        tbl[26] = mk(0, 0, 0, 0, 0, 1, 12'h444, 0, 12'h444, 1, 0, 8);
        tbl[27] = mk(0, 0, 0, 1, 3, 1, 12'h555, 1, 12'h000, 0, 1, 9);
        tbl[28] = mk(1, 0, 1, 0, 0, 1, 12'h555, 0, 12'h000, 0, 0, 0);
        tbl[29] = mk(0, 0, 0, 0, 0, 1, 12'h555, 0, 12'h555, 1, 0, 0);

        @(posedge clk); #1;
        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].rst, tbl[i].fl, tbl[i].st, tbl[i].br, tbl[i].bc, tbl[i].vi, tbl[i].ci);
            #1;
            chk($sformatf("hold[%0d]", i), 32'(hold_upstream), 32'(tbl[i].hold));
            sb_q.push_back('{ec: tbl[i].ec, ev: tbl[i].ev, eb: tbl[i].eb, et: tbl[i].et});
            @(posedge clk); #1;
            e = sb_q.pop_front();
            chk($sformatf("ctrl[%0d]", i),  32'(ctrl_out),     32'(e.ec));
            chk($sformatf("valid[%0d]", i), 32'(valid_out),    32'(e.ev));
            chk($sformatf("busy[%0d]", i),  32'(busy),         32'(e.eb));
            chk($sformatf("total[%0d]", i), 32'(bubble_total), 32'(e.et));
        end

        // Saturation on the 2-bit counter build: four single bubbles, counter stops at 3.
        chk("sat_start", 32'(bubble_total2), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0, 0, 1, 1, 1, 12'h666);
            @(posedge clk); #1;
            drive(0, 0, 0, 0, 0, 1, 12'h666);
            @(posedge clk); #1;
            chk($sformatf("sat_total2[%0d]", k), 32'(bubble_total2), (k > 3) ? 32'd3 : 32'(k));
            chk($sformatf("sat_total[%0d]", k),  32'(bubble_total),  32'(k));
            chk($sformatf("sat_ctrl[%0d]", k),   32'(ctrl_out2),     32'h666);
        end
        drive(0, 0, 0, 1, 0, 1, 12'h777);
        @(posedge clk); #1;
        chk("cnt0_total2", 32'(bubble_total2), 32'd3);
        chk("cnt0_ctrl",   32'(ctrl_out),      32'h777);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
